// File: rtl/txn_timeout_ctrl_if.sv
// Bundle between requesters/downstream target and txn_timeout_ctrl.
// Ports: i_req, i_txn_done in; o_gnt, o_txn_start, o_txn_id, o_done,
// o_err, o_retry_cnt (and o_txn_abort with TXN_TIMEOUT_CTRL_ABORT_EN) out.
interface txn_timeout_ctrl_if #(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 2
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] o_gnt;
    logic             o_txn_start;
    logic [ID_W-1:0]  o_txn_id;
    logic             i_txn_done;
    logic [N_REQ-1:0] o_done;
    logic [N_REQ-1:0] o_err;
    logic [RC_W-1:0]  o_retry_cnt;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
    logic             o_txn_abort;
`endif

    modport master (
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
        input  o_txn_abort,
`endif
        output i_req,
        output i_txn_done,
        input  o_gnt,
        input  o_txn_start,
        input  o_txn_id,
        input  o_done,
        input  o_err,
        input  o_retry_cnt
    );

    modport slave (
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
        output o_txn_abort,
`endif
        input  i_req,
        input  i_txn_done,
        output o_gnt,
        output o_txn_start,
        output o_txn_id,
        output o_done,
        output o_err,
        output o_retry_cnt
    );
endinterface

// File: rtl/txn_timeout_ctrl.sv
// Round-robin arbiter for one slow downstream channel with per-attempt
// timeout, bounded re-issue and error reporting to the owning requester.
// Ports: i_clk, i_rst_n (async, active-low), bus (txn_timeout_ctrl_if.slave).
// Option: define TXN_TIMEOUT_CTRL_ABORT_EN to add bus.o_txn_abort, a
// registered pulse in the cycle after each WAIT timeout.
module txn_timeout_ctrl #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    txn_timeout_ctrl_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPLETE,
        FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             start_q, start_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic             tmo;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
    logic             abort_q, abort_d;
`endif

    // First requester strictly after the last grant, wrapping.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && bus.i_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign tmo = (tmr_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Pulse outputs are computed one cycle early so that every output
    // comes straight from a flop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        rc_d    = rc_q;
        tmr_d   = tmr_q;
        start_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
        abort_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    gnt_d   = N_REQ'(1) << win;
                    id_d    = win;
                    rc_d    = '0;
                    start_d = 1'b1;
                end
            end
            ISSUE: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Saturate so the timer can never wrap.
                tmr_d = tmo ? tmr_q : tmr_q + 1'b1;
                if (bus.i_txn_done) begin
                    state_d = COMPLETE;
                    done_d  = gnt_q;
                end else if (tmo) begin
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
                    abort_d = 1'b1;
`endif
                    if (int'(rc_q) < MAX_RETRY) begin
                        rc_d    = rc_q + 1'b1;
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end else begin
                        state_d = FAIL;
                        err_d   = gnt_q;
                    end
                end
            end
            COMPLETE, FAIL: begin
                gnt_d   = '0;
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            rc_q    <= '0;
            tmr_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            rc_q    <= rc_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_txn_start = start_q;
    assign bus.o_txn_id    = id_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_retry_cnt = rc_q;
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
    assign bus.o_txn_abort = abort_q;
`endif
endmodule

// File: tb/tb_txn_timeout_ctrl.sv
// Directed scoreboard bench for txn_timeout_ctrl
// (N_REQ=4, TIMEOUT_CYCLES=8, MAX_RETRY=2).
module tb_txn_timeout_ctrl;
    localparam int N = 4;
    localparam int T = 8;
    localparam int R = 2;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        int           retry;
        int           id;
        int           starts;
        bit           is_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    txn_timeout_ctrl_if #(.N_REQ(N), .MAX_RETRY(R)) bus ();

    txn_timeout_ctrl #(
        .N_REQ(N),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY(R)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(bus.o_gnt), 0);
        check({tag, "_start"}, 32'(bus.o_txn_start), 0);
        check({tag, "_id"}, 32'(bus.o_txn_id), 0);
        check({tag, "_done"}, 32'(bus.o_done), 0);
        check({tag, "_err"}, 32'(bus.o_err), 0);
        check({tag, "_retry"}, 32'(bus.o_retry_cnt), 0);
    endtask

    // da: attempt that gets i_txn_done (0 = never), dw: WAIT-cycle index
    // of that attempt at which done is driven. lat: check 2-cycle launch.
    task automatic run(input string tag, input logic [N-1:0] req,
                       input int da, input int dw, input int id,
                       input bit hold, input bit lat);
        exp_t e;
        int   att = 0;
        int   idx = 0;
        int   cyc = 0;
        int   first_st = -1;
        int   last_st = -1;
        int   done_cyc = -1;
        int   aborts = 0;
        bit   fin = 1'b0;
        e.is_err = (da == 0);
        e.id     = id;
        e.retry  = e.is_err ? R : da - 1;
        e.starts = e.is_err ? R + 1 : da;
        e.done   = e.is_err ? '0 : N'(1) << id;
        e.err    = e.is_err ? N'(1) << id : '0;
        sb.push_back(e);
        bus.i_req = req;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.o_txn_start) begin
                att++;
                idx = -1;
                check({tag, "_gnt"}, 32'(bus.o_gnt), 32'(N'(1) << id));
                check({tag, "_txn_id"}, 32'(bus.o_txn_id), id);
                if (att > 1)
                    check({tag, "_spacing"}, cyc - last_st, T + 1);
                if (first_st < 0) first_st = cyc;
                last_st = cyc;
                if (!hold) bus.i_req = '0;
            end else if (att > 0) begin
                idx++;
            end
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
            if (bus.o_txn_abort) aborts++;
`endif
            if (|bus.o_done || |bus.o_err) begin
                fin = 1'b1;
                e = sb.pop_front();
                check({tag, "_done"}, 32'(bus.o_done), 32'(e.done));
                check({tag, "_err"}, 32'(bus.o_err), 32'(e.err));
                check({tag, "_retry"}, 32'(bus.o_retry_cnt), e.retry);
                check({tag, "_starts"}, att, e.starts);
                check({tag, "_gnt_held"}, 32'(bus.o_gnt),
                      32'(N'(1) << e.id));
                if (e.is_err)
                    check({tag, "_fail_lat"}, cyc - first_st,
                          (R + 1) * (T + 1));
                else
                    check({tag, "_done_lat"}, cyc - done_cyc, 1);
`ifdef TXN_TIMEOUT_CTRL_ABORT_EN
                check({tag, "_aborts"}, aborts,
                      e.starts - 1 + int'(e.is_err));
`endif
            end
            bus.i_txn_done = (!fin && att == da && idx == dw);
            if (bus.i_txn_done) done_cyc = cyc;
        end
        bus.i_txn_done = 1'b0;
        if (lat) check({tag, "_launch_lat"}, first_st, 1);
        if (!fin) begin
            check({tag, "_budget"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        bus.i_req      = '0;
        bus.i_txn_done = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        run("rr0", 4'b1111, 1, 0, 0, 1'b1, 1'b1);
        run("rr1", 4'b1111, 1, 0, 1, 1'b1, 1'b0);
        run("rr2", 4'b1111, 1, 0, 2, 1'b1, 1'b0);
        run("rr3", 4'b1111, 1, 0, 3, 1'b1, 1'b0);
        run("rr4", 4'b1111, 1, 0, 0, 1'b1, 1'b0);

        run("single", 4'b0001, 1, 4, 0, 1'b0, 1'b0);
        run("retry_ok", 4'b0010, 2, 2, 1, 1'b0, 1'b0);
        run("exhaust", 4'b0100, 0, 0, 2, 1'b0, 1'b0);
        run("after_err", 4'b1111, 1, 0, 3, 1'b0, 1'b0);

        run("simult", 4'b0001, 1, T - 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("simult_no_done", 32'(bus.o_done), 0);
        check("simult_no_err", 32'(bus.o_err), 0);
        check("simult_no_start", 32'(bus.o_txn_start), 0);

        bus.i_req = 4'b0010;
        repeat (4) @(negedge clk);
        bus.i_req = '0;
        check("pre_rst_gnt", 32'(bus.o_gnt), 32'h2);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 4'b0101, 1, 1, 0, 1'b0, 1'b1);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/txn_timeout_ctrl.md
Name: txn_timeout_ctrl

Overview:
- Shares one downstream transaction channel between N_REQ requesters using round-robin arbitration.
- Supervises each granted transaction with an internal timeout counter.
- On timeout, re-issues the transaction up to MAX_RETRY times, then reports an error to the owning requester.
- Sits between requester agents and a single slow downstream target such as a bus bridge or config port.

Parameters:
N_REQ, 4, number of requesters (>=2)
TIMEOUT_CYCLES, 256, WAIT-state cycles allowed per attempt (>=2)
MAX_RETRY, 2, re-issues permitted after the first attempt (>=0)
CNT_W, $clog2(TIMEOUT_CYCLES), timeout counter width (derived)
ID_W, $clog2(N_REQ), grant index width (derived)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_req  in  N_REQ  level request per requester; sampled only in IDLE
o_gnt  out  N_REQ  one-hot grant, held from ISSUE through COMPLETE/FAIL
o_txn_start  out  1  one-cycle pulse launching an attempt downstream
o_txn_id  out  ID_W  index of granted requester, valid while o_gnt != 0
i_txn_done  in  1  downstream completion; honoured only in WAIT
o_done  out  N_REQ  one-cycle one-hot success pulse
o_err  out  N_REQ  one-cycle one-hot failure pulse (retries exhausted)
o_retry_cnt  out  $clog2(MAX_RETRY+1) or 1  retries used in current transaction

Behaviour:
- Reset: state=IDLE; o_gnt=0, o_txn_start=0, o_txn_id=0, o_done=0, o_err=0, o_retry_cnt=0, timer=0. Last-grant pointer = N_REQ-1, so requester 0 wins first.
- All outputs are registered. Reset asserted mid-operation aborts immediately to reset values; no done/err pulse is emitted.
- FSM states: IDLE, ISSUE, WAIT, COMPLETE, FAIL.
- IDLE:
  - If i_req != 0, winner = first set bit strictly after the last-grant pointer, wrapping modulo N_REQ.
  - Next state ISSUE. o_gnt and o_txn_id are loaded. o_retry_cnt=0.
- ISSUE:
  - o_txn_start=1 for exactly this cycle. Timer cleared to 0. Next state WAIT.
- WAIT:
  - Timer increments each cycle, starting at 0 in the first WAIT cycle.
  - If i_txn_done=1: next state COMPLETE. Done has priority over a timeout in the same cycle.
  - Else if timer == TIMEOUT_CYCLES-1 (WAIT lasted exactly TIMEOUT_CYCLES cycles):
    - If o_retry_cnt < MAX_RETRY: o_retry_cnt++ and next state ISSUE.
    - Otherwise next state FAIL.
  - Timer never wraps; it is cleared only in ISSUE.
- COMPLETE:
  - o_done[winner]=1 for one cycle; o_gnt cleared; last-grant pointer = winner. Next state IDLE.
- FAIL:
  - o_err[winner]=1 for one cycle; o_gnt cleared; last-grant pointer = winner. Next state IDLE.
- Latency:
  - Request to o_txn_start: 2 cycles (IDLE sample, then ISSUE).
  - i_txn_done to o_done: 1 cycle.
  - Minimum transaction: 4 cycles (IDLE, ISSUE, WAIT, COMPLETE).
- i_txn_done outside WAIT is ignored.
- i_req changes after grant are ignored; the transaction runs to COMPLETE/FAIL. A requester still requesting is re-arbitrated in the next IDLE.
- o_gnt, o_done and o_err are always zero or one-hot.

Optional Feature:
- Macro: TXN_TIMEOUT_CTRL_ABORT_EN.
- Defined:
  - Adds output o_txn_abort (1 bit).
  - o_txn_abort pulses for one cycle, registered, in the cycle after every WAIT timeout (whether followed by a retry or by FAIL), so the downstream can flush the stale attempt.
  - o_txn_abort and o_txn_start for a retry are in the same cycle.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Single request: N_REQ=4, i_req=0001, i_txn_done asserted 5 cycles after o_txn_start -> one o_txn_start, o_done=0001 one cycle later, o_err=0, o_retry_cnt=0.
- Round-robin: i_req=1111 held, done after 1 WAIT cycle each -> grant order 0,1,2,3,0; o_txn_id matches each grant.
- Timeout with retry success: TIMEOUT_CYCLES=8, MAX_RETRY=2, done only in the 2nd attempt -> 2 o_txn_start pulses 9 cycles apart, o_retry_cnt=1, o_done pulse, no o_err.
- Retries exhausted: TIMEOUT_CYCLES=8, MAX_RETRY=2, done never -> 3 o_txn_start pulses, o_err[winner] after 3x8 WAIT cycles, o_retry_cnt=2, next grant goes to the following requester.
- Simultaneous done and timeout: i_txn_done in the WAIT cycle where timer=7 (TIMEOUT_CYCLES=8) -> o_done, no retry, no o_err; with ABORT_EN, no o_txn_abort.
- Reset mid-WAIT: deassert i_rst_n during WAIT -> all outputs 0 asynchronously; after release, i_req=0100 with pointer reset -> requester 2 granted.
